// File: rtl/ddp_queue_sched.sv
// Weighted round-robin scheduler sharing the DDP packet assembler among NQ transmit queues.
// Optional build macro DDP_SCHED_STRICT_PRI_EN: queue 0 gets strict priority over the WRR queues.
module ddp_queue_sched #(
    parameter int NQ    = 4,
    parameter int LEN_W = 8,
    parameter int WGT_W = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NQ-1:0]       qReq,
    input  logic [NQ*LEN_W-1:0] qLen,
    input  logic                cfgWr,
    input  logic [1:0]          cfgAddr,
    input  logic [WGT_W-1:0]    cfgData,
    input  logic                schedReady,
    input  logic                beatPop,
    input  logic                errClr,
    output logic                schedValid,
    output logic [1:0]          schedQN,
    output logic [LEN_W-1:0]    schedLen,
    output logic                schedDone,
    output logic [1:0]          schedDoneQN,
    output logic                busy,
    output logic                protErr
);

    typedef enum logic [1:0] {IDLE, OFFER, XFER, DONE} state_t;

    state_t             state, state_nxt;
    logic [WGT_W-1:0]   weight [NQ];
    logic [LEN_W-1:0]   q_len  [NQ];
    logic [1:0]         ptr;
    logic [WGT_W-1:0]   burst_cnt;
    logic [LEN_W:0]     beat_cnt;
    logic [NQ-1:0]      elig;
    logic               any_elig;
    logic [1:0]         sel;
    logic               burst_cont;
    logic               last_beat;
    logic               upd_ptr;

    always_comb begin
        for (int i = 0; i < NQ; i++) begin
            q_len[i] = qLen[i*LEN_W +: LEN_W];
            elig[i]  = qReq[i] && (weight[i] != '0);
        end
    end

    assign any_elig = |elig;

    // Scan from the highest offset down so the entry nearest ptr wins.
    always_comb begin
        logic [1:0] idx;
        sel = ptr;
        for (int k = NQ-1; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (elig[idx]) sel = idx;
        end
`ifdef DDP_SCHED_STRICT_PRI_EN
        if (elig[0]) sel = 2'd0;
`endif
    end

    assign burst_cont = (({1'b0, burst_cnt} + 1'b1) < {1'b0, weight[schedQN]}) && qReq[schedQN];
    assign last_beat  = beatPop && (beat_cnt == (LEN_W+1)'(1));

`ifdef DDP_SCHED_STRICT_PRI_EN
    // Queue-0 grants bypass the round-robin bookkeeping entirely.
    assign upd_ptr = (schedQN != 2'd0);
`else
    assign upd_ptr = 1'b1;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_elig) state_nxt = OFFER;
            OFFER:   if (schedReady) state_nxt = XFER;
            XFER:    if (last_beat) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NQ; i++) weight[i] <= WGT_W'(1);
            ptr       <= '0;
            burst_cnt <= '0;
            beat_cnt  <= '0;
            schedQN   <= '0;
            schedLen  <= '0;
            protErr   <= 1'b0;
        end else begin
            if (cfgWr) weight[cfgAddr] <= cfgData;
            // A new error in the same cycle as errClr keeps the flag set.
            protErr <= (protErr && !errClr) || (beatPop && state != XFER);
            case (state)
                IDLE: if (any_elig) begin
                    schedQN  <= sel;
                    schedLen <= q_len[sel];
                end
                OFFER: if (schedReady) beat_cnt <= {schedLen == '0, schedLen};
                XFER:  if (beatPop) beat_cnt <= beat_cnt - 1'b1;
                DONE: if (upd_ptr) begin
                    if (burst_cont) begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end else begin
                        ptr       <= schedQN + 2'd1;
                        burst_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign schedValid  = (state == OFFER);
    assign schedDone   = (state == DONE);
    assign schedDoneQN = schedDone ? schedQN : 2'd0;
    assign busy        = (state != IDLE);

endmodule
